// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction-fetch and load/store ports onto a
// single-port RAM with a shared tristate data bus. Each access runs
// IDLE -> ACC -> ACK, with a registered one-cycle ack on the winning port.
// Optional feature: define MEMCTRL_FAIRNESS_EN for round-robin arbitration
// on simultaneous requests; otherwise the data port has fixed priority.
module mem_ctrl #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [AWIDTH-1:0] ifAddr,
  output logic              ifAck,
  output logic [DWIDTH-1:0] ifData,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [AWIDTH-1:0] dAddr,
  input  logic [DWIDTH-1:0] dWdata,
  output logic              dAck,
  output logic [DWIDTH-1:0] dRdata,
  output logic [AWIDTH-1:0] ramAddr,
  output logic              ramRdEn,
  output logic              ramWrEn,
  inout  wire  [DWIDTH-1:0] ramData,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

  state_t            state, state_next;
  logic              grant;
  logic              grantData;
  logic              isData_q;
  logic [DWIDTH-1:0] wdata_q;

`ifdef MEMCTRL_FAIRNESS_EN
  logic              lastData_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and arbitration decision
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grantData  = 1'b0;
    case (state)
      IDLE: begin
        if (ifReq || dReq) begin
          grant = 1'b1;
`ifdef MEMCTRL_FAIRNESS_EN
          // On a tie, the port that lost the previous arbitration wins.
          grantData = dReq && (!ifReq || !lastData_q);
`else
          grantData = dReq;
`endif
          state_next = ACC;
        end
      end
      ACC:     state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef MEMCTRL_FAIRNESS_EN
  // Remember which port won the last arbitration; data counts as last after reset
  always_ff @(posedge clk) begin
    if (reset)      lastData_q <= 1'b1;
    else if (grant) lastData_q <= grantData;
  end
`endif

  // Transaction latch, RAM strobes, read capture and acks
  always_ff @(posedge clk) begin
    if (reset) begin
      isData_q <= 1'b0;
      wdata_q  <= '0;
      ramAddr  <= '0;
      ramRdEn  <= 1'b0;
      ramWrEn  <= 1'b0;
      ifAck    <= 1'b0;
      dAck     <= 1'b0;
      ifData   <= '0;
      dRdata   <= '0;
    end else begin
      ifAck <= 1'b0;
      dAck  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            isData_q <= grantData;
            wdata_q  <= dWdata;
            ramAddr  <= grantData ? dAddr : ifAddr;
            ramRdEn  <= !(grantData && dWe);
            ramWrEn  <= grantData && dWe;
          end
        end
        ACC: begin
          ramRdEn <= 1'b0;
          ramWrEn <= 1'b0;
          if (isData_q) begin
            dAck <= 1'b1;
            if (!ramWrEn) dRdata <= ramData;
          end else begin
            ifAck  <= 1'b1;
            ifData <= ramData;
          end
        end
        default: ;
      endcase
    end
  end

  // ramWrEn is high only in ACC of a store, so it doubles as the bus-drive
  // enable; reset releases the bus immediately rather than at the next edge.
  assign ramData = (ramWrEn && !reset) ? wdata_q : 'z;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a behavioural 256x32 RAM,
// followed by random mixed traffic with bus-discipline and read-data checks.
module tb_mem_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clk;
  logic          reset;
  logic          ifReq;
  logic [AW-1:0] ifAddr;
  logic          ifAck;
  logic [DW-1:0] ifData;
  logic          dReq;
  logic          dWe;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic          dAck;
  logic [DW-1:0] dRdata;
  logic [AW-1:0] ramAddr;
  logic          ramRdEn;
  logic          ramWrEn;
  wire  [DW-1:0] ramData;
  logic          busy;

  // backdoor preload port of the RAM model
  logic          bdWe;
  logic [AW-1:0] bdAddr;
  logic [DW-1:0] bdData;
  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifAck(ifAck), .ifData(ifData),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dAck(dAck), .dRdata(dRdata),
    .ramAddr(ramAddr), .ramRdEn(ramRdEn), .ramWrEn(ramWrEn),
    .ramData(ramData), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: drives the bus on read, captures on the rising edge on write
  assign ramData = ramRdEn ? mem[ramAddr] : 'z;
  always @(posedge clk) begin
    if (ramWrEn)   mem[ramAddr] <= ramData;
    else if (bdWe) mem[bdAddr]  <= bdData;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic bus_free();
    return (ramData === {DW{1'bz}}) || (ramData === '0);
  endfunction

  logic [11:0] ifSeen, dSeen;
  int          ifAt, dAt;
  int          bothEn, busDriven, badRead, loads, fetches;

  initial begin
    reset = 1'b1; ifReq = 0; ifAddr = '0; dReq = 0; dWe = 0; dAddr = '0; dWdata = '0;
    bdWe = 1'b1; bdAddr = 8'd3; bdData = 32'h6403_0080;
    tick();
    bdAddr = 8'd5; bdData = 32'h0000_0555;
    tick();
    bdAddr = 8'd9; bdData = 32'h0000_0099;
    tick();
    bdWe = 1'b0;
    tick();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rden", {31'b0, ramRdEn}, 0);
    check("rst_wren", {31'b0, ramWrEn}, 0);
    check("rst_addr", {24'b0, ramAddr}, 0);
    check("rst_acks", {30'b0, ifAck, dAck}, 0);
    check("rst_bus", {31'b0, bus_free()}, 1);
    reset = 1'b0;

    // fetch from address 3
    ifReq = 1; ifAddr = 8'd3;
    tick();
    check("f_rden", {31'b0, ramRdEn}, 1);
    check("f_addr", {24'b0, ramAddr}, 3);
    check("f_busy", {31'b0, busy}, 1);
    check("f_ack_early", {31'b0, ifAck}, 0);
    tick();
    check("f_ack", {31'b0, ifAck}, 1);
    check("f_data", ifData, 32'h6403_0080);
    check("f_dack", {31'b0, dAck}, 0);
    check("f_rden_off", {31'b0, ramRdEn}, 0);
    ifReq = 0;
    tick();
    check("f_ack_low", {31'b0, ifAck}, 0);
    check("f_idle", {31'b0, busy}, 0);

    // store then load at 0x81
    dReq = 1; dWe = 1; dAddr = 8'h81; dWdata = 32'hDEAD_BEEF;
    tick();
    check("s_wren", {31'b0, ramWrEn}, 1);
    check("s_rden", {31'b0, ramRdEn}, 0);
    check("s_bus", ramData, 32'hDEAD_BEEF);
    dWdata = 32'h1111_1111; dAddr = 8'h00;
    tick();
    check("s_ack", {31'b0, dAck}, 1);
    check("s_wren_off", {31'b0, ramWrEn}, 0);
    check("s_bus_rel", {31'b0, bus_free()}, 1);
    check("s_mem", mem[8'h81], 32'hDEAD_BEEF);
    dReq = 0;
    tick();
    check("s_ack_low", {31'b0, dAck}, 0);
    dReq = 1; dWe = 0; dAddr = 8'h81;
    tick();
    tick();
    check("l_ack", {31'b0, dAck}, 1);
    check("l_data", dRdata, 32'hDEAD_BEEF);
    dReq = 0;
    tick();

    // both requests held continuously for four transactions
    ifReq = 1; ifAddr = 8'd9; dReq = 1; dWe = 0; dAddr = 8'd5;
    for (int t = 0; t < 12; t++) begin
      tick();
      ifSeen[t] = ifAck;
      dSeen[t]  = dAck;
    end
    ifReq = 0; dReq = 0;
`ifdef MEMCTRL_FAIRNESS_EN
    check("held_if", {20'b0, ifSeen}, 32'h082);
    check("held_d", {20'b0, dSeen}, 32'h410);
`else
    check("held_if", {20'b0, ifSeen}, 32'h000);
    check("held_d", {20'b0, dSeen}, 32'h492);
`endif
    tick();

    // simultaneous single-shot requests, each dropped at its own ack
    ifAt = 0; dAt = 0;
    ifReq = 1; dReq = 1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (dAck)  begin dAt = t;  dReq = 0;  end
      if (ifAck) begin ifAt = t; ifReq = 0; end
    end
`ifdef MEMCTRL_FAIRNESS_EN
    check("tie_if_at", ifAt, 2);
    check("tie_d_at", dAt, 5);
`else
    check("tie_d_at", dAt, 2);
    check("tie_if_at", ifAt, 5);
`endif
    check("tie_drdata", dRdata, 32'h0000_0555);
    check("tie_ifdata", ifData, 32'h0000_0099);

    // reset while a load is in ACC
    dReq = 1; dWe = 0; dAddr = 8'h81;
    tick();
    check("rl_rden", {31'b0, ramRdEn}, 1);
    reset = 1;
    tick();
    check("rl_rden0", {31'b0, ramRdEn}, 0);
    check("rl_wren0", {31'b0, ramWrEn}, 0);
    check("rl_addr0", {24'b0, ramAddr}, 0);
    check("rl_acks0", {30'b0, ifAck, dAck}, 0);
    check("rl_drdata0", dRdata, 0);
    check("rl_ifdata0", ifData, 0);
    check("rl_busy0", {31'b0, busy}, 0);
    check("rl_bus", {31'b0, bus_free()}, 1);
    reset = 0;
    tick();
    tick();
    check("rl_fresh_ack", {31'b0, dAck}, 1);
    check("rl_fresh_data", dRdata, 32'hDEAD_BEEF);
    dReq = 0;
    tick();

    // reset asserted during a store's ACC releases the bus at once
    dReq = 1; dWe = 1; dAddr = 8'h40; dWdata = 32'h1234_5678;
    tick();
    check("rs_wren", {31'b0, ramWrEn}, 1);
    reset = 1; dReq = 0;
    #1;
    check("rs_bus_rel", {31'b0, bus_free()}, 1);
    tick();
    check("rs_wren0", {31'b0, ramWrEn}, 0);
    reset = 0;
    tick();

    // random mixed traffic
    bothEn = 0; busDriven = 0; badRead = 0; loads = 0; fetches = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (ramRdEn && ramWrEn) bothEn++;
      if (!ramRdEn && !ramWrEn && !bus_free()) busDriven++;
      if (dAck) begin
        if (!dWe) begin
          loads++;
          if (dRdata !== mem[dAddr]) badRead++;
        end
        dReq = 0;
      end else if (!dReq && ($urandom_range(1, 0) == 1)) begin
        dReq = 1; dWe = $urandom_range(1, 0) == 1;
        dAddr = AW'($urandom_range(255, 0)); dWdata = $urandom | 32'h1;
      end
      if (ifAck) begin
        fetches++;
        if (ifData !== mem[ifAddr]) badRead++;
        ifReq = 0;
      end else if (!ifReq && ($urandom_range(1, 0) == 1)) begin
        ifReq = 1; ifAddr = AW'($urandom_range(255, 0));
      end
    end
    check("rnd_both_en", bothEn, 0);
    check("rnd_bus_driven", busDriven, 0);
    check("rnd_bad_read", badRead, 0);
    check("rnd_loads_seen", {31'b0, loads > 100}, 1);
    check("rnd_fetches_seen", {31'b0, fetches > 100}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller placed directly upstream of the 256 x 32 RAM. It arbitrates between the processor's instruction-fetch port and its load/store data port, and serialises their accesses onto the RAM's shared tristate data bus. The RAM bus uses one-hot `rdEn`/`wrEn` and a word address. Each transaction completes with a registered one-cycle acknowledge on the requesting port.

## Interface
- `DWIDTH`, 32, data word width
- `AWIDTH`, 8, word address width (256 words)

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high reset
- `ifReq`  in  1  fetch request (level, held until `ifAck`)
- `ifAddr`  in  AWIDTH  fetch word address
- `ifAck`  out  1  one-cycle pulse: `ifData` valid
- `ifData`  out  DWIDTH  fetched word, held until next fetch completes
- `dReq`  in  1  data request (level, held until `dAck`)
- `dWe`  in  1  1 = store, 0 = load
- `dAddr`  in  AWIDTH  data word address
- `dWdata`  in  DWIDTH  store data
- `dAck`  out  1  one-cycle pulse: store done or `dRdata` valid
- `dRdata`  out  DWIDTH  loaded word, held until next load completes
- `ramAddr`  out  AWIDTH  RAM address (registered)
- `ramRdEn`  out  1  RAM read enable
- `ramWrEn`  out  1  RAM write enable
- `ramData`  inout  DWIDTH  RAM data bus; driven only during a write access, else `z`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACC, ACK.
- **IDLE.** Sample `ifReq` and `dReq`. If either is high, latch the winner's address, `dWe` and `dWdata` into internal registers. Load `ramAddr`, and set `ramRdEn` (fetch or load) or `ramWrEn` (store). Go to ACC.
- **ACC.** The RAM is accessed during this cycle.
  - Read: `ramData` is sampled at the ACC→ACK edge into `ifData` or `dRdata`.
  - Write: the controller drives `ramData` = latched `dWdata` for this whole cycle. The RAM captures it at the ACC→ACK edge.
  - Leaving ACC, clear `ramRdEn`/`ramWrEn` and assert the winner's ack. Go to ACK.
- **ACK.** The ack is high for this one cycle. Requests are ignored in this state. Go to IDLE.
- Requester rule: deassert `req` on the edge that ends the ack cycle. A `req` still high in IDLE is treated as a new transaction.
- Arbitration default: data port has fixed priority over fetch. The losing request stays pending and is granted on a later IDLE.
- `ramRdEn` and `ramWrEn` are never high together. Both are low outside ACC.
- `ramData` is released (`z`) in every state except ACC-write, and during reset.
- Address and data inputs are sampled only in IDLE. Changes after the grant do not affect the transaction in flight.
- Reset (synchronous, any state):
  - state ← IDLE
  - `ramAddr` ← 0, `ramRdEn`/`ramWrEn` ← 0, `ramData` released
  - `ifAck`/`dAck` ← 0, `ifData`/`dRdata` ← 0, `busy` ← 0
  - An in-flight transaction is dropped with no ack; a store in ACC may or may not have landed in the RAM.

## Timing
- `req` sampled high at edge N, state IDLE → ACC at N. RAM is enabled during cycle N..N+1.
- Edge N+1: read data captured, ack goes high.
- Edge N+2: ack goes low, state returns to IDLE.
- Issue interval: one transaction per 3 cycles. The earliest next grant is at edge N+3.
- Latency is identical for loads, stores and fetches.
- `busy` = 1 for cycles N..N+2.

## Configuration
- `MEMCTRL_FAIRNESS_EN`
  - Defined: round-robin arbitration. When both requests are pending in IDLE, grant the port that did not win the previous arbitration. After reset, the data port is considered last-granted, so fetch wins the first tie. Single requests are granted immediately regardless of history.
  - Not defined: fixed data-over-fetch priority; no last-grant register is built.

## Test plan
- Fetch read: RAM[3] preloaded `0x6403_0080`; `ifReq`=1, `ifAddr`=3 at edge N → `ramRdEn`=1 in cycle N, `ifAck`=1 and `ifData`=`0x6403_0080` after N+1, `dAck` stays 0.
- Store then load: store `0xDEAD_BEEF` to address `0x81` → `ramWrEn`=1 and `ramData` driven for exactly one cycle, `dAck` pulse. A following load from `0x81` → `dRdata`=`0xDEAD_BEEF`.
- Simultaneous requests without macro: `ifReq`=`dReq`=1 (load from 5) in IDLE → data granted first. Fetch is granted at the first IDLE after the data ack; `ifAck` asserts 3 cycles after `dAck`.
- Simultaneous requests with `MEMCTRL_FAIRNESS_EN`: both requests held continuously → grants alternate fetch, data, fetch, data; acks spaced 3 cycles apart.
- Reset mid-access: assert `reset` while in ACC of a load → next cycle all outputs are 0, `ramData` is `z`, no `dAck`. A fresh request after reset completes normally.
- Bus discipline: random mixed traffic for 10,000 cycles → `ramRdEn & ramWrEn` never 1, and `ramData` is never driven outside ACC-write.
